i2c_byte_master: RTL and testbench
==================================

Name: i2c_byte_master

Overview:
- Byte-level I2C master PHY that sits directly downstream of the EEPROM controller; consumes its start/stop/write/read command pulses and drives the SCL/SDA pins.
- Reports byte completion (done), slave ACK status (ack_err), received data and a busy flag back to the controller.
- Each tick advances one quarter of an SCL bit, so a 400 kHz tick gives a 100 kHz SCL.

Parameters:
BUS_FREE_TICKS, 4, ticks SCL and SDA stay released after a STOP before a pending START is launched (range 1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
tick  in  1  one-clk strobe; all bus timing and command sampling happen only on clk edges where tick=1
start  in  1  issue START, or repeated START when already in a transaction
stop  in  1  issue STOP
write  in  1  transmit data_in (MSB first), then sample the slave ACK
read  in  1  receive one byte, then send ack_in
data_in  in  8  byte to transmit
ack_in  in  1  ACK bit sent after a read byte: 0=ACK, 1=NACK
busy  out  1  0 only in IDLE or HOLD (ready for a command)
done  out  1  one-clk pulse at the end of each write or read byte (after the 9th bit)
ack_err  out  1  write: 1 if the slave NACKed; read: always 0; valid from done until the next byte's done
data_out  out  8  last received byte; updated on the read done
scl  out  1  SCL level (1 = released)
sda_oe  out  1  1 = pull SDA low; 0 = release
sda_i  in  1  SDA pin level

Behaviour:
- Reset (reset=0 at clk edge) output values: busy=0, done=0, ack_err=0, data_out=8'h00, scl=1, sda_oe=0.
  - Reset also clears the pending-command flags and sets state IDLE.
  - Reset mid-byte aborts immediately with no STOP generated; the bus is released the next cycle.
- Command capture: only on a tick while busy=0.
  - All asserted command inputs are latched together as pending flags (pend_stop, pend_start, pend_wr, pend_rd), along with data_in and ack_in; busy rises on the next clk.
  - Commands while busy=1 are ignored.
  - In IDLE, only start is honoured. stop, write or read without start is discarded and busy stays 0.
- Execution order of pending flags: STOP, then bus-free wait, then START, then write. read is executed only if write is not pending; write wins.
- Quarter phases, one per tick, Q0..Q3.
  - Q0: SCL low, SDA updated.
  - Q1: SCL high.
  - Q2: SCL high, sda_i sampled.
  - Q3: SCL low.
- States:
  - IDLE: scl=1, sda_oe=0.
  - START:
    - Q0: release SDA.
    - Q1: SCL high.
    - Q2: pull SDA low with SCL high.
    - Q3: SCL low.
    - From HOLD this produces a repeated START.
  - WBIT: 8 bits, MSB first, sda_oe = ~bit.
  - WACK: SDA released; sda_i captured at Q2 into ack_err.
  - RBIT: 8 bits, SDA released; sda_i shifted in at Q2, MSB first.
  - RACK: sda_oe = ~ack_in (latched).
  - STOP:
    - Q0: SDA low.
    - Q1: SCL high.
    - Q2: release SDA.
    - Q3: hold.
    - Then BUS_FREE_TICKS ticks with the bus released.
  - HOLD: scl=0, SDA as left; busy=0.
- Transitions:
  - IDLE->START on pend_start.
  - START->WBIT if pend_wr; START->RBIT if pend_rd; otherwise START->HOLD.
  - WBIT->WACK->HOLD; RBIT->RACK->HOLD.
  - HOLD->STOP/START/WBIT/RBIT per the pending flags.
  - STOP->(bus-free)->START if pend_start; otherwise STOP->(bus-free)->IDLE.
- done timing:
  - Pulses on the clk edge of the Q3 tick of WACK/RACK. busy falls on that same edge.
  - data_out and ack_err are updated on that same edge.
  - No done is generated for START or STOP.
- Latency: byte 36 ticks; START 4 ticks; STOP 4 + BUS_FREE_TICKS ticks.
  - START+write from IDLE: done on the 40th tick after capture.
- No clock stretching and no arbitration; sda_i is ignored outside Q2 of WACK and RBIT.

Test Plan:
1. Reset, then start+write with data_in=8'hA0 in IDLE, slave ACKs → START, SDA bits 1,0,1,0,0,0,0,0; done on tick 40; ack_err=0; busy returns to 0 with scl=0.
2. Write 8'h12 from HOLD, slave leaves SDA high on the 9th bit → done after 36 ticks with ack_err=1; a following stop gives a STOP and busy=0 in IDLE after 4+4 ticks.
3. Repeated start+write 8'hA1, then read with ack_in=1, slave drives 8'h5A → data_out=8'h5A on done; sda_oe=0 during the 9th bit; ack_err=0.
4. stop+start+write(8'hA0) captured on one tick from HOLD → STOP, 4 released ticks, START, byte; exactly one done.
5. write pulsed while busy=1, and stop alone in IDLE → both ignored: no extra done; busy/scl/sda_oe unchanged.
6. reset=0 at bit 5 of a write → next cycle: scl=1, sda_oe=0, busy=0, data_out=8'h00; a new start+write runs normally.

Source files
------------

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master PHY driven by start/stop/write/read command pulses.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | bus released, waiting for a start command
// START   | (repeated) START condition, four quarter phases
// WBIT    | shifting out 8 data bits, MSB first
// WACK    | SDA released, slave ACK sampled
// RBIT    | SDA released, 8 data bits shifted in, MSB first
// RACK    | master drives the latched ACK/NACK bit
// STOP    | STOP condition, four quarter phases
// FREE    | bus-free wait after STOP, SCL and SDA released
// HOLD    | SCL low, SDA as left, ready for the next command
module i2c_byte_master #(
  parameter int BUS_FREE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] data_in,
  input  logic       ack_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] data_out,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_WBIT  = 4'd2;
  localparam logic [3:0] S_WACK  = 4'd3;
  localparam logic [3:0] S_RBIT  = 4'd4;
  localparam logic [3:0] S_RACK  = 4'd5;
  localparam logic [3:0] S_STOP  = 4'd6;
  localparam logic [3:0] S_FREE  = 4'd7;
  localparam logic [3:0] S_HOLD  = 4'd8;

  localparam logic [3:0] FREE_LOAD = 4'(BUS_FREE_TICKS - 1);

  logic [3:0] state;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [3:0] free_cnt;
  logic [7:0] shreg;
  logic [7:0] data_l;
  logic       ack_l;
  logic       ack_s;
  logic       pend_start;
  logic       pend_wr;
  logic       pend_rd;
  logic       cmd_take;

  // Ready for a command only when parked; a bare stop/write/read in IDLE is dropped.
  always_comb begin
    busy     = (state != S_IDLE) && (state != S_HOLD);
    cmd_take = tick && !busy && ((state == S_HOLD) || start);
  end

  // Command dispatch, quarter-phase sequencing and bus pin drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      phase      <= 2'd0;
      bit_cnt    <= 3'd0;
      free_cnt   <= 4'd0;
      shreg      <= 8'h00;
      data_l     <= 8'h00;
      ack_l      <= 1'b0;
      ack_s      <= 1'b0;
      pend_start <= 1'b0;
      pend_wr    <= 1'b0;
      pend_rd    <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      data_out   <= 8'h00;
      scl        <= 1'b1;
      sda_oe     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_take) begin
        data_l <= data_in;
        ack_l  <= ack_in;
        phase  <= 2'd0;
        if (stop) begin
          state      <= S_STOP;
          pend_start <= start;
          pend_wr    <= write;
          pend_rd    <= read;
        end else if (start) begin
          state      <= S_START;
          pend_start <= 1'b0;
          pend_wr    <= write;
          pend_rd    <= read;
        end else if (write) begin
          state   <= S_WBIT;
          shreg   <= data_in;
          bit_cnt <= 3'd7;
          pend_wr <= 1'b0;
          pend_rd <= 1'b0;
        end else if (read) begin
          state   <= S_RBIT;
          bit_cnt <= 3'd7;
          pend_rd <= 1'b0;
        end
      end else if (tick) begin
        phase <= phase + 2'd1;
        case (state)
          S_START: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= 1'b0; end
              2'd1: scl <= 1'b1;
              2'd2: sda_oe <= 1'b1;
              default: begin
                scl <= 1'b0;
                // write wins over read; the losing read is discarded
                if (pend_wr) begin
                  state   <= S_WBIT;
                  shreg   <= data_l;
                  bit_cnt <= 3'd7;
                  pend_wr <= 1'b0;
                  pend_rd <= 1'b0;
                end else if (pend_rd) begin
                  state   <= S_RBIT;
                  bit_cnt <= 3'd7;
                  pend_rd <= 1'b0;
                end else begin
                  state <= S_HOLD;
                end
              end
            endcase
          end
          S_WBIT: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= ~shreg[7]; end
              2'd1: scl <= 1'b1;
              2'd2: scl <= 1'b1;
              default: begin
                scl   <= 1'b0;
                shreg <= {shreg[6:0], 1'b0};
                if (bit_cnt == 3'd0) state <= S_WACK;
                else bit_cnt <= bit_cnt - 3'd1;
              end
            endcase
          end
          S_WACK: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= 1'b0; end
              2'd1: scl <= 1'b1;
              2'd2: ack_s <= sda_i;
              default: begin
                scl     <= 1'b0;
                done    <= 1'b1;
                ack_err <= ack_s;
                state   <= S_HOLD;
              end
            endcase
          end
          S_RBIT: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= 1'b0; end
              2'd1: scl <= 1'b1;
              2'd2: shreg <= {shreg[6:0], sda_i};
              default: begin
                scl <= 1'b0;
                if (bit_cnt == 3'd0) state <= S_RACK;
                else bit_cnt <= bit_cnt - 3'd1;
              end
            endcase
          end
          S_RACK: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= ~ack_l; end
              2'd1: scl <= 1'b1;
              2'd2: scl <= 1'b1;
              default: begin
                scl      <= 1'b0;
                done     <= 1'b1;
                ack_err  <= 1'b0;
                data_out <= shreg;
                state    <= S_HOLD;
              end
            endcase
          end
          S_STOP: begin
            case (phase)
              2'd0: begin scl <= 1'b0; sda_oe <= 1'b1; end
              2'd1: scl <= 1'b1;
              2'd2: sda_oe <= 1'b0;
              default: begin
                free_cnt <= FREE_LOAD;
                state    <= S_FREE;
              end
            endcase
          end
          S_FREE: begin
            if (free_cnt == 4'd0) begin
              phase <= 2'd0;
              if (pend_start) begin
                state      <= S_START;
                pend_start <= 1'b0;
              end else begin
                state   <= S_IDLE;
                pend_wr <= 1'b0;
                pend_rd <= 1'b0;
              end
            end else begin
              free_cnt <= free_cnt - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a wired-AND slave model on SDA.
module tb_i2c_byte_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic       write;
  logic       read;
  logic [7:0] data_in;
  logic       ack_in;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] data_out;
  logic       scl;
  logic       sda_oe;
  logic       sda_i;
  logic       slave_low;

  int npass = 0;
  int ntot  = 0;

  // recorder state
  int          k;
  int          done_cnt;
  int          done_at;
  int          idle_at;
  int          start_cnt;
  int          stop_cnt;
  logic        busy_at_done;
  logic [15:0] bits;
  logic [63:0] oe_hist;
  logic [63:0] scl_hist;
  logic        p_scl;
  logic        p_oe;
  logic        s_scl, s_oe, s_busy, s_done;

  assign sda_i = ~(sda_oe | slave_low);

  always #5 clk = ~clk;

  i2c_byte_master #(.BUS_FREE_TICKS(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .write(write), .read(read), .data_in(data_in), .ack_in(ack_in),
    .busy(busy), .done(done), .ack_err(ack_err), .data_out(data_out),
    .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One tick with the currently driven commands, followed by one idle clk.
  task automatic step();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    s_scl = scl; s_oe = sda_oe; s_busy = busy; s_done = done;
    tick = 1'b0; start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    k = 0; done_cnt = 0; done_at = 0; idle_at = 0; start_cnt = 0; stop_cnt = 0;
    busy_at_done = 1'b1; bits = '0; oe_hist = '0; scl_hist = '0;
    p_scl = scl; p_oe = sda_oe;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      k++;
      if (s_done) begin done_cnt++; done_at = k; busy_at_done = s_busy; end
      if (!s_busy && idle_at == 0) idle_at = k;
      if (s_scl && !p_scl) bits = {bits[14:0], ~s_oe};
      if (s_scl && p_scl && s_oe && !p_oe) start_cnt++;
      if (s_scl && p_scl && !s_oe && p_oe) stop_cnt++;
      if (k < 64) begin oe_hist[k] = s_oe; scl_hist[k] = s_scl; end
      p_scl = s_scl; p_oe = s_oe;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd_byte;
    logic       ok;
    reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; write = 1'b0; read = 1'b0;
    data_in = 8'h00; ack_in = 1'b0; slave_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    @(negedge clk);
    reset = 1'b1;

    // start+write A0 from IDLE, slave ACKs
    slave_low = 1'b1;
    start = 1'b1; write = 1'b1; data_in = 8'hA0;
    step();
    chk("t1_busy_rise", busy, 1);
    clear_rec();
    run_ticks(40);
    chk("t1_done_at", done_at, 40);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_start_cnt", start_cnt, 1);
    chk("t1_bits", bits[8:1], 8'hA0);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_scl_hold", scl, 0);

    // repeated start+write A1 from HOLD
    start = 1'b1; write = 1'b1; data_in = 8'hA1;
    step();
    clear_rec();
    run_ticks(40);
    chk("t3_rs_start_cnt", start_cnt, 1);
    chk("t3_rs_done_at", done_at, 40);
    chk("t3_rs_bits", bits[8:1], 8'hA1);

    // read with NACK, slave returns 5A
    read = 1'b1; ack_in = 1'b1;
    step();
    clear_rec();
    rd_byte = 8'h5A;
    for (int b = 7; b >= 0; b--) begin
      slave_low = ~rd_byte[b];
      run_ticks(4);
    end
    slave_low = 1'b0;
    run_ticks(4);
    chk("t3_rd_done_at", done_at, 36);
    chk("t3_rd_done_cnt", done_cnt, 1);
    chk("t3_rd_data_out", data_out, 8'h5A);
    chk("t3_rd_ack_err", ack_err, 0);
    chk("t3_rd_oe_9th", oe_hist[36:33], 4'h0);

    // write 12 from HOLD, slave NACKs
    slave_low = 1'b0;
    write = 1'b1; data_in = 8'h12;
    step();
    clear_rec();
    run_ticks(36);
    chk("t2_done_at", done_at, 36);
    chk("t2_ack_err", ack_err, 1);
    chk("t2_bits", bits[8:1], 8'h12);

    // stop+start+write A0 on one tick from HOLD
    slave_low = 1'b1;
    stop = 1'b1; start = 1'b1; write = 1'b1; data_in = 8'hA0;
    step();
    clear_rec();
    run_ticks(48);
    chk("t4_stop_cnt", stop_cnt, 1);
    chk("t4_start_cnt", start_cnt, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_at", done_at, 48);
    chk("t4_bits", bits[8:1], 8'hA0);
    ok = 1'b1;
    for (int j = 5; j <= 8; j++) ok = ok & scl_hist[j] & ~oe_hist[j];
    chk("t4_bus_free", ok, 1);

    // stop alone from HOLD
    stop = 1'b1;
    step();
    clear_rec();
    run_ticks(8);
    chk("t2_stop_cnt", stop_cnt, 1);
    chk("t2_idle_at", idle_at, 8);
    chk("t2_idle_scl", scl, 1);
    chk("t2_idle_oe", sda_oe, 0);

    // stop alone in IDLE is discarded
    stop = 1'b1;
    step();
    chk("t5_idle_stop_busy", busy, 0);
    clear_rec();
    run_ticks(4);
    chk("t5_idle_stop_done", done_cnt, 0);
    chk("t5_idle_stop_scl", scl, 1);
    chk("t5_idle_stop_oe", sda_oe, 0);

    // write pulsed while busy is ignored
    slave_low = 1'b0;
    start = 1'b1; write = 1'b1; data_in = 8'hA0;
    step();
    clear_rec();
    run_ticks(10);
    write = 1'b1; data_in = 8'h12;
    run_ticks(34);
    chk("t5_busy_done_cnt", done_cnt, 1);
    chk("t5_busy_done_at", done_at, 40);
    chk("t5_busy_bits", bits[8:1], 8'hA0);
    chk("t5_busy_ack_err", ack_err, 1);
    chk("t5_busy_end", busy, 0);

    // reset during bit 5 of a write
    stop = 1'b1;
    step();
    run_ticks(8);
    start = 1'b1; write = 1'b1; data_in = 8'hA0;
    step();
    clear_rec();
    run_ticks(25);
    chk("t6_pre_oe", sda_oe, 1);
    chk("t6_pre_scl", scl, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_rst_scl", scl, 1);
    chk("t6_rst_oe", sda_oe, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_data_out", data_out, 8'h00);
    chk("t6_rst_ack_err", ack_err, 0);
    @(negedge clk);
    reset = 1'b1;
    slave_low = 1'b1;
    start = 1'b1; write = 1'b1; data_in = 8'h3C;
    step();
    clear_rec();
    run_ticks(40);
    chk("t6_new_done_at", done_at, 40);
    chk("t6_new_bits", bits[8:1], 8'h3C);
    chk("t6_new_ack_err", ack_err, 0);
    chk("t6_new_busy", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
